// File: rtl/psx_ram_pkg.sv
// Shared types for the CPU main-RAM posted-write buffer.
package psx_ram_pkg;

  typedef struct packed {
    logic [26:0] addr;
    logic [31:0] din;
    logic [3:0]  be;
  } wbuf_entry_t;

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} wbuf_state_t;

endpackage

// File: rtl/psx_ram_wbuf_fifo.sv
// Flop-based write FIFO; a push into a full FIFO is legal when a pop shares the cycle.
module psx_ram_wbuf_fifo
  import psx_ram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk_base,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [$bits(wbuf_entry_t)-1:0] wr_data,
  output logic [$bits(wbuf_entry_t)-1:0] head,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          full,
  output logic                          empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = $bits(wbuf_entry_t);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;

  // Pointers wrap naturally; the level counter tells full from empty.
  always_ff @(posedge clk_base or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk_base) begin
    if (push) mem[wptr] <= wr_data;
  end

  assign head  = mem[rptr];
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/psx_ram_wbuf.sv
// CPU main-RAM port: posted writes into a FIFO, reads ordered behind them,
// single requests to SDRAM channel 2 using its edge-triggered req/ready handshake.
module psx_ram_wbuf
  import psx_ram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_base,
  input  logic                   reset_n,
  input  logic                   cpu_req,
  input  logic                   cpu_rnw,
  input  logic [26:0]            cpu_addr,
  input  logic [31:0]            cpu_din,
  input  logic [3:0]             cpu_be,
  output logic                   cpu_done,
  output logic [31:0]            cpu_dout,
  output logic [26:0]            ch2_addr,
  output logic [31:0]            ch2_din,
  output logic [3:0]             ch2_be,
  output logic                   ch2_rnw,
  output logic                   ch2_req,
  input  logic                   ch2_ready,
  input  logic [31:0]            ch2_dout,
  output logic                   wbuf_empty,
  output logic [$clog2(DEPTH):0] wbuf_level
);

  wbuf_state_t state, state_n;
  logic        pend_vld, pend_rnw;
  logic [24:0] pend_addr;
  logic [31:0] pend_din;
  logic [3:0]  pend_be;
  logic        req_vld, req_rnw;
  logic [24:0] req_addr;
  logic [31:0] req_din;
  logic [3:0]  req_be;
  logic        ready_q, ch2_done, push, pop, rd_done;
  logic        fifo_full, fifo_empty, issue_wr, issue_rd;
  wbuf_entry_t wr_entry, head;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^cpu_addr[1:0];

  // A request is serviceable in its arrival cycle; the slot holds it afterwards.
  assign req_vld  = pend_vld | cpu_req;
  assign req_rnw  = pend_vld ? pend_rnw  : cpu_rnw;
  assign req_addr = pend_vld ? pend_addr : cpu_addr[26:2];
  assign req_din  = pend_vld ? pend_din  : cpu_din;
  assign req_be   = pend_vld ? pend_be   : cpu_be;

  assign ch2_done   = ch2_ready & ~ready_q;
  assign pop        = (state == WR_WAIT) & ch2_done;
  assign rd_done    = (state == RD_WAIT) & ch2_done;
  assign push       = req_vld & ~req_rnw & (~fifo_full | pop);
  assign wr_entry   = {req_addr, 2'b00, req_din, req_be};
  assign wbuf_empty = fifo_empty & (state != WR_WAIT);

  psx_ram_wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_base (clk_base),
    .reset_n  (reset_n),
    .push     (push),
    .pop      (pop),
    .wr_data  (wr_entry),
    .head     (head),
    .level    (wbuf_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_n  = state;
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          issue_wr = 1'b1;
          state_n  = WR_WAIT;
        end else if (req_vld && req_rnw) begin
          issue_rd = 1'b1;
          state_n  = RD_WAIT;
        end
      end
      WR_WAIT: if (ch2_done) state_n = IDLE;
      RD_WAIT: if (ch2_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_base or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ready_q   <= 1'b0;
      pend_vld  <= 1'b0;
      pend_rnw  <= 1'b0;
      pend_addr <= '0;
      pend_din  <= '0;
      pend_be   <= '0;
      cpu_done  <= 1'b0;
      cpu_dout  <= '0;
      ch2_req   <= 1'b0;
      ch2_rnw   <= 1'b0;
      ch2_addr  <= '0;
      ch2_din   <= '0;
      ch2_be    <= '0;
    end else begin
      state    <= state_n;
      ready_q  <= ch2_ready;
      cpu_done <= push | rd_done;
      if (rd_done) cpu_dout <= ch2_dout;
      // Issue only from IDLE, so req is always a single-cycle pulse.
      ch2_req <= issue_wr | issue_rd;
      if (issue_wr) begin
        ch2_addr <= head.addr;
        ch2_din  <= head.din;
        ch2_be   <= head.be;
        ch2_rnw  <= 1'b0;
      end else if (issue_rd) begin
        ch2_addr <= {req_addr, 2'b00};
        ch2_be   <= 4'hF;
        ch2_rnw  <= 1'b1;
      end
      if (push || rd_done) pend_vld <= 1'b0;
      else if (cpu_req)    pend_vld <= 1'b1;
      if (cpu_req) begin
        pend_rnw  <= cpu_rnw;
        pend_addr <= cpu_addr[26:2];
        pend_din  <= cpu_din;
        pend_be   <= cpu_be;
      end
    end
  end

endmodule

// File: doc/psx_ram_wbuf.md
# psx_ram_wbuf

Posted-write buffer and request sequencer for the CPU main-RAM port. It sits directly upstream of SDRAM channel 2 (32-bit, byte-enabled), in the `clk_base` (~33 MHz) domain. CPU writes are absorbed into a FIFO and return done in one cycle. Reads are ordered behind all buffered writes, then issued as single requests that follow channel 2's edge-triggered req/ready protocol.

## Interface
- `DEPTH`, 4: write FIFO entries; power of two, 2..16.
- `clk_base`  in  1  system clock; SDRAM channel 2 ready is synchronous to it.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  single-cycle request pulse; one outstanding request maximum.
- `cpu_rnw`  in  1  1 = read, 0 = write.
- `cpu_addr`  in  27  byte address; [1:0] ignored.
- `cpu_din`  in  32  write data.
- `cpu_be`  in  4  write byte enables; bit n covers [8n+7:8n].
- `cpu_done`  out  1  single-cycle completion pulse.
- `cpu_dout`  out  32  read data; valid while `cpu_done` = 1, then held.
- `ch2_addr`  out  27  SDRAM address, always `{addr[26:2],2'b00}`.
- `ch2_din`  out  32  SDRAM write data.
- `ch2_be`  out  4  SDRAM byte enables; forced to 4'hF for reads.
- `ch2_rnw`  out  1  SDRAM direction.
- `ch2_req`  out  1  request; the SDRAM side acts on its rising edge.
- `ch2_ready`  in  1  completion level; high for 1–2 cycles per operation.
- `ch2_dout`  in  32  read data; valid while `ch2_ready` = 1.
- `wbuf_empty`  out  1  FIFO empty and no write in flight.
- `wbuf_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Reset values:** FIFO empty; state IDLE; `cpu_done`, `ch2_req`, `ch2_rnw` = 0; `cpu_dout`, `ch2_addr`, `ch2_din` = 0; `ch2_be` = 0; `wbuf_empty` = 1; `wbuf_level` = 0; pending slot invalid; `ready_q` = 0.
- **Pending slot.** Every `cpu_req` is latched into a one-deep pending slot holding rnw, addr, din and be.
- **Writes.** A pending write pushes into the FIFO in any cycle where the FIFO is not full, or where a pop occurs in the same cycle. `cpu_done` pulses the cycle after the push.
- **Reads.** A pending read waits until the FIFO is empty and the state is IDLE. It is then issued; reads are never forwarded from the FIFO.
- **Ready detection.** `ready_q` registers `ch2_ready`. Completion is `ch2_ready & ~ready_q`, a rising edge. A held-high ready never counts twice.
- **FSM states:**
  - IDLE: if the FIFO is not empty, load the head into the `ch2_*` outputs, set `ch2_req` = 1, go to WR_WAIT. Otherwise, if a read is pending, load it, set `ch2_req` = 1, go to RD_WAIT.
  - WR_WAIT: clear `ch2_req` after one cycle. On completion, pop the head and go to IDLE.
  - RD_WAIT: clear `ch2_req` after one cycle. On completion, capture `ch2_dout` into `cpu_dout`, pulse `cpu_done` next cycle, clear the pending slot, go to IDLE.
- **Output stability.** `ch2_*` outputs other than `ch2_req` stay stable from req rise until completion.
- **Priority.** Writes already in the FIFO drain before any read, which gives strict program order.
- **Full FIFO.** A write arriving while full stalls in the pending slot and `cpu_done` is delayed. This is the only CPU backpressure.
- **Simultaneous push and pop.** Legal; `wbuf_level` stays unchanged.
- **Wrap-around.** Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty is distinguished by the level counter.
- **Reset mid-operation.** All state clears immediately. A `ch2_ready` edge arriving later lands in IDLE and is ignored. The SDRAM side completes its access, and the data is discarded.

## Timing
- **Write to empty, idle buffer.** `cpu_req` at cycle T. Push at edge T+1, `cpu_done` = 1 in T+1. `ch2_req` = 1 in T+2 only. `wbuf_empty` = 0 from T+1 until the cycle after completion.
- **Read with empty buffer.** `cpu_req` at T; `ch2_req` = 1 in T+1 only. Ready edge sampled in cycle R; `cpu_done` and `cpu_dout` valid in R+1.
- **Req spacing.** `ch2_req` is never high in two consecutive cycles. Back-to-back requests have at least one low cycle between them, so every issue is a fresh rising edge.
- **Steady-state throughput.** One SDRAM operation per completion plus one cycle.

## Structure
- Shared package `psx_ram_pkg` holds:
  - the FIFO entry struct `{addr[26:0], din[31:0], be[3:0]}`;
  - the state enum (IDLE, WR_WAIT, RD_WAIT).
- One sub-module, `psx_ram_wbuf_fifo`: synchronous FIFO with flop storage, push/pop, level, full/empty, and async active-low reset.
- The FSM, pending slot and ready edge detection live in the top module.

## Test plan
- **Single write.** Write addr 0x0001000, data 0xDEADBEEF, be 4'b0011. Expect `cpu_done` at T+1; `ch2_req` pulse at T+2 with `ch2_addr` 0x0001000, `ch2_be` 4'b0011; `wbuf_level` 1 → 0 after ready.
- **Full FIFO.** With `ch2_ready` held low, issue DEPTH+1 writes. Expect 4 immediate dones; the 5th done arrives only in the cycle after the first ready edge; FIFO order is preserved at the `ch2_*` outputs.
- **Read ordering.** Do 3 writes, then a read to 0x0002004. Expect 3 write reqs, then a read req with `ch2_rnw` = 1 and `ch2_be` 4'hF. The model returns 0x12345678, and `cpu_dout` = 0x12345678 with `cpu_done` one cycle after the ready edge.
- **Long ready.** Hold `ch2_ready` high for 2 cycles. Expect exactly one pop and one `ch2_req` pulse per edge.
- **Reset mid-operation.** Assert `reset_n` low during RD_WAIT, then deliver ready after release. Expect no `cpu_done`, `wbuf_level` 0, and `ch2_req` 0.
- **Simultaneous push and pop.** Push a new write in the same cycle a write completes. Expect the level unchanged and the new entry issued after the current head.
